encode_fp: RTL and testbench

ENCODE_FP -- requirements
Module: encode_fp

---
 rtl/encode_fp.sv | 93 +++++++++
 tb/tb_encode_fp.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/encode_fp.sv
// encode_fp: converts BCD fraction 0.<Digit_1><Digit_2> to IEEE-754 half precision.
// Define ENCODE_FP_ROUND_EN for round-to-nearest on pack; otherwise the mantissa is truncated.
module encode_fp (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic [3:0]  Digit_1,
    input  logic [3:0]  Digit_2,
    output logic [15:0] Fp_out,
    output logic        Done
);
    typedef enum logic [4:0] {
        st_init      = 5'b00001,
        st_divide    = 5'b00010,
        st_normalize = 5'b00100,
        st_pack      = 5'b01000,
        st_done_con  = 5'b10000
    } state_t;
    state_t      state;
    logic [6:0]  val;
    logic [15:0] frac;
    logic [4:0]  exponent;
    logic [3:0]  cnt;
    logic [7:0]  rem2;
    logic        ge;
    logic [15:0] packed_w;
    // val doubles as the running remainder of the long division
    assign rem2 = {val, 1'b0};
    assign ge   = rem2 >= 8'd100;
`ifdef ENCODE_FP_ROUND_EN
    logic [10:0] mant_r;
    assign mant_r   = {1'b0, frac[14:5]} + {10'b0, frac[4]};
    assign packed_w = mant_r[10] ? {1'b0, exponent + 5'd1, 10'b0} : {1'b0, exponent, mant_r[9:0]};
`else
    assign packed_w = {1'b0, exponent, frac[14:5]};
`endif
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= st_init;
            val      <= '0;
            frac     <= '0;
            exponent <= '0;
            cnt      <= '0;
            Fp_out   <= '0;
            Done     <= 1'b0;
        end else begin
            case (state)
                st_init: if (Start) begin
                    cnt <= '0;
                    // NaN is encoded through frac/exponent so pack needs no special case
                    if (Digit_1 > 4'd9 || Digit_2 > 4'd9) begin
                        frac     <= 16'hC000;
                        exponent <= 5'h1F;
                        state    <= st_pack;
                    end else begin
                        val      <= 7'(Digit_1) * 7'd10 + 7'(Digit_2);
                        frac     <= '0;
                        exponent <= 5'd14;
                        state    <= st_divide;
                    end
                end
                st_divide: begin
                    val   <= ge ? 7'(rem2 - 8'd100) : rem2[6:0];
                    frac  <= {frac[14:0], ge};
                    cnt   <= cnt + 4'd1;
                    state <= (cnt == 4'd15) ? st_normalize : st_divide;
                end
                st_normalize: begin
                    if (frac == 16'h0000) begin
                        exponent <= '0;
                        state    <= st_pack;
                    end else if (frac[15]) begin
                        state <= st_pack;
                    end else begin
                        frac     <= frac << 1;
                        exponent <= exponent - 5'd1;
                    end
                end
                st_pack: begin
                    Fp_out <= packed_w;
                    Done   <= 1'b1;
                    state  <= st_done_con;
                end
                st_done_con: if (Ack) begin
                    Done  <= 1'b0;
                    state <= st_init;
                end
                default: state <= st_init;
            endcase
        end
    end
endmodule

// File: tb/tb_encode_fp.sv
// tb_encode_fp: directed vectors for encode_fp; a driver queues expected results and
// a monitor checks value and latency on every rising Done.
module tb_encode_fp;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Ack = 1'b0;
    logic [3:0]  Digit_1 = '0;
    logic [3:0]  Digit_2 = '0;
    logic [15:0] Fp_out;
    logic        Done;

    typedef struct {
        logic [15:0] fp;
        int          lat;
        int          start;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic done_q = 1'b0;

    encode_fp dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .Digit_1(Digit_1), .Digit_2(Digit_2), .Fp_out(Fp_out), .Done(Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (Done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got Done=1 with fp %h expected none", Fp_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fp_out", 32'(Fp_out), 32'(e.fp));
                chk("latency", 32'(cyc - e.start), 32'(e.lat));
            end
        end
        done_q = Done;
    end

    task automatic run(input logic [3:0] d1, input logic [3:0] d2, input logic [15:0] fp,
                       input int lat, input int hold, input bit disturb);
        exp_t e;
        int n;
        bit bad;
        @(negedge Clk);
        Digit_1 = d1;
        Digit_2 = d2;
        Start = 1'b1;
        e.fp = fp;
        e.lat = lat;
        e.start = cyc + 1;
        sb.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        Digit_1 = 4'd9;
        Digit_2 = 4'd9;
        if (disturb && lat > 2) begin
            repeat (4) @(negedge Clk);
            Start = 1'b1;
            Ack = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
            Ack = 1'b0;
        end
        n = 0;
        while (!Done && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!Done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got Done=0 expected Done=1 within 200 cycles");
        end
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            Start = disturb && i[0];
            @(negedge Clk);
            if (!Done || Fp_out !== fp) bad = 1'b1;
        end
        Start = 1'b0;
        if (hold > 0) chk("hold_stable", 32'(bad), 32'd0);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("done_cleared", 32'(Done), 32'd0);
        chk("fp_held_after_ack", 32'(Fp_out), 32'(fp));
    endtask

    initial begin
        #1;
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_fp", 32'(Fp_out), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run(4'd5, 4'd0, 16'h3800, 18, 0, 1'b0);
        run(4'd0, 4'd5, 16'h2A66, 22, 0, 1'b0);
        run(4'd1, 4'd0, 16'h2E66, 21, 0, 1'b1);
`ifdef ENCODE_FP_ROUND_EN
        run(4'd9, 4'd5, 16'h3B9A, 18, 50, 1'b1);
        run(4'd9, 4'd9, 16'h3BEC, 18, 0, 1'b0);
`else
        run(4'd9, 4'd5, 16'h3B99, 18, 50, 1'b1);
        run(4'd9, 4'd9, 16'h3BEB, 18, 0, 1'b0);
`endif
        run(4'd0, 4'd1, 16'h211E, 24, 0, 1'b0);
        run(4'd0, 4'd0, 16'h0000, 18, 3, 1'b1);
        run(4'd15, 4'd15, 16'h7E00, 1, 0, 1'b0);
        run(4'd10, 4'd0, 16'h7E00, 1, 0, 1'b0);
        run(4'd2, 4'd5, 16'h3400, 19, 0, 1'b0);
        // abort mid-divide: nothing is queued, so any Done pulse is flagged by the monitor
        @(negedge Clk);
        Digit_1 = 4'd5;
        Digit_2 = 4'd0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_fp", 32'(Fp_out), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (40) @(negedge Clk);
        chk("abort_no_done", 32'(Done), 32'd0);
        chk("abort_fp_idle", 32'(Fp_out), 32'd0);
        run(4'd5, 4'd0, 16'h3800, 18, 0, 1'b0);
        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
